// File: rtl/game_ctrl_fsm.sv
// Game-control sequencer: seed source select, LFSR control, paced generation ticks, run/pause/step.
// Optional auto-stop at max_gen is enabled by defining GAME_CTRL_AUTOSTOP_EN.
module game_ctrl_fsm #(
    parameter int GEN_W = 16,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rand_seed,
    input  logic             pause,
    input  logic             step,
    input  logic [DIV_W-1:0] speed_div,
    input  logic [GEN_W-1:0] max_gen,
    output logic             mux_start,
    output logic             show_rand_seed,
    output logic             lfsr_begin,
    output logic             lfsr_load,
    output logic             gen_tick,
    output logic [GEN_W-1:0] gen_count,
    output logic             running,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED_RAND,
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               start_prev_q, step_prev_q;
    logic               src_rand_q, src_rand_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [GEN_W-1:0]   gen_count_q, gen_count_d;
    logic               gen_tick_q, gen_tick_d;
    logic               start_e, step_e;
    logic               div_wrap;
    logic [GEN_W-1:0]   gen_count_inc;
    logic               stop_hit;

    assign start_e       = start & ~start_prev_q;
    assign step_e        = step & ~step_prev_q;
    assign div_wrap      = (div_cnt_q == speed_div);
    assign gen_count_inc = gen_count_q + 1'b1;

`ifdef GAME_CTRL_AUTOSTOP_EN
    assign stop_hit = (max_gen != '0) && (gen_count_inc == max_gen);
`else
    logic unused_max_gen;
    assign unused_max_gen = ^max_gen;
    assign stop_hit       = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        src_rand_d  = src_rand_q;
        div_cnt_d   = div_cnt_q;
        gen_count_d = gen_count_q;
        gen_tick_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_e) begin
                    state_d    = S_LOAD;
                    src_rand_d = rand_seed;
                end else if (rand_seed) begin
                    state_d = S_SEED_RAND;
                end
            end
            S_SEED_RAND: begin
                if (start_e) begin
                    state_d    = S_LOAD;
                    src_rand_d = 1'b1;
                end else if (!rand_seed) begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                state_d     = S_RUN;
                div_cnt_d   = '0;
                gen_count_d = '0;
            end
            S_RUN: begin
                // div_cnt only advances while actually running, so a pause freezes the phase
                if (start_e) begin
                    state_d = S_IDLE;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else begin
                    div_cnt_d  = div_wrap ? '0 : div_cnt_q + 1'b1;
                    gen_tick_d = div_wrap;
                    if (div_wrap && stop_hit) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_PAUSE: begin
                if (start_e) begin
                    state_d = S_IDLE;
                end else if (!pause) begin
                    state_d = S_RUN;
                end else if (step_e) begin
                    gen_tick_d = 1'b1;
                    if (stop_hit) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (start_e) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (gen_tick_d) begin
            gen_count_d = gen_count_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b1;
            step_prev_q  <= 1'b1;
            src_rand_q   <= 1'b0;
            div_cnt_q    <= '0;
            gen_count_q  <= '0;
            gen_tick_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start;
            step_prev_q  <= step;
            src_rand_q   <= src_rand_d;
            div_cnt_q    <= div_cnt_d;
            gen_count_q  <= gen_count_d;
            gen_tick_q   <= gen_tick_d;
        end
    end

    always_comb begin
        mux_start      = (state_q == S_LOAD) || (state_q == S_RUN) ||
                         (state_q == S_PAUSE) || (state_q == S_DONE);
        show_rand_seed = (state_q == S_SEED_RAND) || (mux_start && src_rand_q);
        lfsr_begin     = (state_q == S_SEED_RAND);
        lfsr_load      = (state_q == S_LOAD) && src_rand_q;
        gen_tick       = gen_tick_q;
        gen_count      = gen_count_q;
        running        = (state_q == S_RUN);
`ifdef GAME_CTRL_AUTOSTOP_EN
        done           = (state_q == S_DONE);
`else
        done           = 1'b0;
`endif
    end

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Bench for game_ctrl_fsm: expected ticks (cycle, count, done) are queued at stimulus time
// and matched by a monitor whenever gen_tick fires.
module tb_game_ctrl_fsm;

    localparam int GEN_W = 16;
    localparam int DIV_W = 24;

    logic             clk = 1'b0;
    logic             reset, start, rand_seed, pause, step;
    logic [DIV_W-1:0] speed_div;
    logic [GEN_W-1:0] max_gen;
    logic             mux_start, show_rand_seed, lfsr_begin, lfsr_load;
    logic             gen_tick, running, done;
    logic [GEN_W-1:0] gen_count;

    game_ctrl_fsm #(.GEN_W(GEN_W), .DIV_W(DIV_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .rand_seed     (rand_seed),
        .pause         (pause),
        .step          (step),
        .speed_div     (speed_div),
        .max_gen       (max_gen),
        .mux_start     (mux_start),
        .show_rand_seed(show_rand_seed),
        .lfsr_begin    (lfsr_begin),
        .lfsr_load     (lfsr_load),
        .gen_tick      (gen_tick),
        .gen_count     (gen_count),
        .running       (running),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        int unsigned cnt;
        logic        dn;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned c0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] outs();
        return {mux_start, show_rand_seed, lfsr_begin, lfsr_load, gen_tick, running, done};
    endfunction

    always @(negedge clk) begin
        if (gen_tick === 1'b1) begin
            if (sb.size() == 0) begin
                chk("tick_unexpected", 32'(gen_tick), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("tick_cyc", cyc, e.cyc);
                chk("tick_cnt", 32'(gen_count), e.cnt);
                chk("tick_done", 32'(done), 32'(e.dn));
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b1; rand_seed = 1'b0; pause = 1'b0; step = 1'b0;
        speed_div = 24'd3; max_gen = 16'd0;

        // reset with start held: no edge until a real re-press
        repeat (3) step_clk();
        chk("rst_outs", 32'(outs()), 32'd0);
        chk("rst_cnt", 32'(gen_count), 32'd0);
        reset = 1'b0;
        repeat (2) step_clk();
        chk("held_start_no_load", 32'(outs()), 32'd0);
        start = 1'b0;
        step_clk();
        chk("idle_outs", 32'(outs()), 32'd0);

        // manual seed, speed_div=3: ticks at N+6, period 4
        c0 = cyc;
        start = 1'b1;
        for (int i = 0; i < 5; i++) sb.push_back('{c0 + 6 + 4 * i, i + 1, 1'b0});
        step_clk();
        chk("load_mux", 32'(mux_start), 32'd1);
        chk("load_no_lfsr_load", 32'(lfsr_load), 32'd0);
        start = 1'b0;
        step_clk();
        chk("run_state", 32'(running), 32'd1);
        repeat (20) step_clk();
        chk("cnt_after_5", 32'(gen_count), 32'd5);
        repeat (3) step_clk();
        start = 1'b1;
        step_clk();
        chk("abort_run_idle", 32'(outs()), 32'd0);
        start = 1'b0;
        step_clk();
        chk("sb_drain_1", sb.size(), 32'd0);

        // random seed path; step in IDLE ignored
        speed_div = 24'd1000;
        step = 1'b1; step_clk(); step = 1'b0; step_clk();
        chk("idle_step_ignored", 32'(outs()), 32'd0);
        rand_seed = 1'b1;
        step_clk();
        chk("seed_rand_decode", 32'({mux_start, show_rand_seed, lfsr_begin}), 32'b011);
        rand_seed = 1'b0;
        start = 1'b1;
        step_clk();
        chk("rand_lfsr_load", 32'(lfsr_load), 32'd1);
        chk("rand_load_decode", 32'({mux_start, show_rand_seed, lfsr_begin}), 32'b110);
        start = 1'b0;
        step_clk();
        chk("rand_load_pulse_end", 32'(lfsr_load), 32'd0);
        chk("rand_run", 32'({running, show_rand_seed}), 32'b11);
        start = 1'b1; step_clk();
        chk("rand_abort", 32'(running), 32'd0);
        start = 1'b0; step_clk();

        // pause / single-step with speed_div=9
        speed_div = 24'd9;
        c0 = cyc;
        start = 1'b1;
        sb.push_back('{c0 + 12, 1, 1'b0});
        sb.push_back('{c0 + 22, 2, 1'b0});
        step_clk();
        start = 1'b0;
        repeat (21) step_clk();
        pause = 1'b1;
        step_clk();
        chk("pause_state", 32'({running, mux_start}), 32'b01);
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            sb.push_back('{cyc + 1, 3 + p, 1'b0});
            step_clk();
            step = 1'b0;
            repeat (2) step_clk();
        end
        chk("pause_cnt", 32'(gen_count), 32'd5);
        chk("pause_still", 32'(running), 32'd0);
        pause = 1'b0;
        sb.push_back('{cyc + 11, 6, 1'b0});
        step_clk();
        chk("resume_run", 32'(running), 32'd1);
        repeat (10) step_clk();
        chk("resume_cnt", 32'(gen_count), 32'd6);
        start = 1'b1; step_clk();
        start = 1'b0; step_clk();
        chk("sb_drain_2", sb.size(), 32'd0);

        // auto-stop at max_gen=4 with speed_div=0
        speed_div = 24'd0;
        max_gen = 16'd4;
        c0 = cyc;
        start = 1'b1;
`ifdef GAME_CTRL_AUTOSTOP_EN
        for (int i = 0; i < 4; i++) sb.push_back('{c0 + 3 + i, i + 1, (i == 3)});
`else
        for (int i = 0; i < 10; i++) sb.push_back('{c0 + 3 + i, i + 1, 1'b0});
`endif
        step_clk();
        start = 1'b0;
        repeat (11) step_clk();
`ifdef GAME_CTRL_AUTOSTOP_EN
        chk("autostop_done", 32'({done, running}), 32'b10);
        chk("autostop_cnt", 32'(gen_count), 32'd4);
`else
        chk("no_autostop_done", 32'({done, running}), 32'b01);
        chk("no_autostop_cnt", 32'(gen_count), 32'd10);
`endif
        start = 1'b1;
        step_clk();
        chk("stop_abort_idle", 32'(outs()), 32'd0);
        start = 1'b0;
        max_gen = 16'd0;
        step_clk();
        chk("sb_drain_3", sb.size(), 32'd0);

        // simultaneous start and rand_seed in IDLE, then mid-run reset
        speed_div = 24'd1000;
        start = 1'b1; rand_seed = 1'b1;
        step_clk();
        chk("simul_load", 32'({mux_start, show_rand_seed, lfsr_load}), 32'b111);
        start = 1'b0; rand_seed = 1'b0;
        step_clk();
        chk("simul_run", 32'({running, show_rand_seed}), 32'b11);
        reset = 1'b1;
        step_clk();
        chk("midrun_reset_outs", 32'(outs()), 32'd0);
        chk("midrun_reset_cnt", 32'(gen_count), 32'd0);
        reset = 1'b0;
        step_clk();
        chk("post_reset_idle", 32'(outs()), 32'd0);
        chk("sb_drain_final", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
